shifter_pipe: RTL and testbench

Parametrised, pipelined barrel shifter with valid/ready handshakes. It is the next generation of the team's 32-bit combinational shifter: configurable width and pipeline depth, and rotate modes in addition to logical and arithmetic shifts. It also carries an opaque tag per operation. It sits between the ALU issue stage and writeback, and accepts one operation per cycle when not back-pressured.

---
 rtl/shifter_pkg.sv | 21 ++
 rtl/shifter_stage.sv | 81 ++++++++
 rtl/shifter_pipe.sv | 99 +++++++++
 tb/tb_shifter_pipe.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op codes and the
// split of mux levels across pipeline stages.
package shifter_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        SH_SLL = 3'b000,
        SH_SRL = 3'b001,
        SH_SRA = 3'b010,
        SH_ROL = 3'b011,
        SH_ROR = 3'b100
    } sh_op_e;

    // Mux levels per stage, rounded up; the last stage absorbs whatever is left.
    function automatic int unsigned levels_per_stage(input int unsigned levels,
                                                     input int unsigned stages);
        return (levels + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/shifter_stage.sv
// One pipeline slice of shifter_pipe: NLEV mux levels starting at level LO, then
// the valid/data/tag register. Rotate levels exist only with SHIFTER_ROTATE_EN.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned LO    = 0,
    parameter int unsigned NLEV  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     adv,
    input  logic                     up_valid,
    input  logic [WIDTH-1:0]         up_data,
    input  logic [$clog2(WIDTH)-1:0] up_shamt,
    input  logic [OP_W-1:0]          up_op,
    input  logic [TAG_W-1:0]         up_tag,
    output logic                     valid,
    output logic [WIDTH-1:0]         data,
    output logic [$clog2(WIDTH)-1:0] shamt,
    output logic [OP_W-1:0]          op,
    output logic [TAG_W-1:0]         tag
);

    localparam int unsigned SW = $clog2(WIDTH);

    logic [WIDTH-1:0] shifted;

    // Single mux level k: moves the operand by 2^k according to op.
    function automatic logic [WIDTH-1:0] level(input logic [WIDTH-1:0] d,
                                               input logic [OP_W-1:0]  o,
                                               input int unsigned      k);
        int unsigned      s;
        logic [WIDTH-1:0] r;
        s = 1 << k;
        r = d;
        case (o)
            SH_SLL: r = d << s;
            SH_SRL: r = d >> s;
            SH_SRA: r = $signed(d) >>> s;
`ifdef SHIFTER_ROTATE_EN
            SH_ROL: r = (d << s) | (d >> (WIDTH - s));
            SH_ROR: r = (d >> s) | (d << (WIDTH - s));
`else
            SH_ROL, SH_ROR: r = d;
`endif
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        shifted = up_data;
        for (int unsigned j = 0; j < NLEV; j++) begin
            if (up_shamt[SW'(LO + j)]) begin
                shifted = level(shifted, up_op, LO + j);
            end
        end
    end

    // Payload only loads on a real operation; bubbles just clear valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            shamt <= '0;
            op    <= '0;
            tag   <= '0;
        end else if (adv) begin
            valid <= up_valid;
            if (up_valid) begin
                data  <= shifted;
                shamt <= up_shamt;
                op    <= up_op;
                tag   <= up_tag;
            end
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// Parametrised pipelined barrel shifter with valid/ready handshakes and a tag
// sideband. Define SHIFTER_ROTATE_EN to enable the ROL/ROR datapath.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         din,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [OP_W-1:0]          op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         dout,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_zero
);

    localparam int unsigned SW  = $clog2(WIDTH);
    localparam int unsigned PER = levels_per_stage(SW, STAGES);

    // Index 0 is the input port; index i+1 is the register of stage i.
    logic             v   [STAGES+1];
    logic [WIDTH-1:0] d   [STAGES+1];
    logic [SW-1:0]    s   [STAGES+1];
    logic [OP_W-1:0]  o   [STAGES+1];
    logic [TAG_W-1:0] t   [STAGES+1];
    logic             adv [STAGES+1];
    logic             chain;

    assign v[0] = in_valid;
    assign d[0] = din;
    assign s[0] = shamt;
    assign o[0] = op;
    assign t[0] = in_tag;

    // Stall chain walked from the output back to stage 0 through a scratch
    // variable so no array element depends combinationally on another.
    always_comb begin
        chain       = !out_valid || out_ready;
        adv[STAGES] = chain;
        for (int unsigned i = 0; i < STAGES; i++) begin
            chain                = !v[STAGES - i] || chain;
            adv[STAGES - 1 - i]  = chain;
        end
    end

    assign in_ready = rst_n && adv[0];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int unsigned LO = (gi * PER < SW) ? gi * PER : SW;
        localparam int unsigned HI = (gi == STAGES - 1) ? SW :
                                     (((gi + 1) * PER < SW) ? (gi + 1) * PER : SW);

        shifter_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .LO    (LO),
            .NLEV  (HI - LO)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .adv      (adv[gi]),
            .up_valid (v[gi]),
            .up_data  (d[gi]),
            .up_shamt (s[gi]),
            .up_op    (o[gi]),
            .up_tag   (t[gi]),
            .valid    (v[gi+1]),
            .data     (d[gi+1]),
            .shamt    (s[gi+1]),
            .op       (o[gi+1]),
            .tag      (t[gi+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            out_tag   <= '0;
            out_zero  <= 1'b0;
        end else if (adv[STAGES]) begin
            out_valid <= v[STAGES];
            if (v[STAGES]) begin
                dout     <= d[STAGES];
                out_tag  <= t[STAGES];
                out_zero <= (d[STAGES] == '0);
            end
        end
    end

endmodule

// File: tb/tb_shifter_pipe.sv
// Scoreboard bench for shifter_pipe at WIDTH=32, STAGES=2, TAG_W=4; rotate
// expectations follow SHIFTER_ROTATE_EN.
module tb_shifter_pipe;

`ifdef SHIFTER_ROTATE_EN
    localparam logic ROT = 1'b1;
`else
    localparam logic ROT = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] din = '0;
    logic [4:0]  shamt = '0;
    logic [2:0]  op = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] dout;
    logic [3:0]  out_tag;
    logic        out_zero;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic        stream_done;

    always #5 clk = ~clk;

    shifter_pipe #(
        .WIDTH  (32),
        .STAGES (2),
        .TAG_W  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .shamt     (shamt),
        .op        (op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_tag   (out_tag),
        .out_zero  (out_zero)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent reference: whole-amount shifts, rotates via a doubled word.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] d,
                                          input logic [4:0] s);
`ifdef SHIFTER_ROTATE_EN
        logic [63:0] w;
`endif
        case (o)
            3'd0: return d << s;
            3'd1: return d >> s;
            3'd2: return 32'($signed(d) >>> s);
`ifdef SHIFTER_ROTATE_EN
            3'd3: begin w = {d, d} << s; return w[63:32]; end
            3'd4: begin w = {d, d} >> s; return w[31:0]; end
`endif
            default: return d;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [2:0] o, input logic [31:0] d, input logic [4:0] s,
                        input logic [3:0] t, input logic [31:0] e);
        int unsigned n;
        n        = 0;
        op       = o;
        din      = d;
        shamt    = s;
        in_tag   = t;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1 (tag %0d)", t);
            in_valid = 1'b0;
        end else begin
            sb.push_back('{data: e, tag: t, zero: (e == 32'h0)});
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: every transfer on the output side must match the next queued result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got tag %0d data 0x%0h, expected no output",
                         out_tag, dout);
            end else begin
                mon_e = sb.pop_front();
                chk("dout", 64'(dout), 64'(mon_e.data));
                chk("out_tag", 64'(out_tag), 64'(mon_e.tag));
                chk("out_zero", 64'(out_zero), 64'(mon_e.zero));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] rd;
        logic [4:0]  rs;
        stream_done = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("in_ready_in_reset", 64'(in_ready), 64'd0);
        chk("out_valid_reset", 64'(out_valid), 64'd0);
        chk("dout_reset", 64'(dout), 64'd0);
        chk("out_tag_reset", 64'(out_tag), 64'd0);
        chk("out_zero_reset", 64'(out_zero), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        // First op with latency check
        send(3'd0, 32'hAAAAAAAA, 5'd2, 4'd1, 32'hAAAAAAA8);
        chk("latency_edge0", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("latency_edge1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("latency_edge2", 64'(out_valid), 64'd1);
        drain();

        // Directed vectors, streamed back to back
        send(3'd1, 32'hAAAAAAAA, 5'd2,  4'd2, 32'h2AAAAAAA);
        send(3'd2, 32'hFFFFFFFA, 5'd2,  4'd3, 32'hFFFFFFFE);
        send(3'd2, 32'h7FFFFFFF, 5'd31, 4'd4, 32'h00000000);
        send(3'd3, 32'h80000001, 5'd4,  4'd5, ROT ? 32'h00000018 : 32'h80000001);
        send(3'd4, 32'h00000001, 5'd1,  4'd6, ROT ? 32'h80000000 : 32'h00000001);
        send(3'd2, 32'h80000001, 5'd0,  4'd7, 32'h80000001);
        send(3'd3, 32'hDEADBEEF, 5'd0,  4'd8, 32'hDEADBEEF);
        send(3'd5, 32'h12345678, 5'd7,  4'd9, 32'h12345678);
        send(3'd7, 32'hCAFEF00D, 5'd31, 4'd10, 32'hCAFEF00D);
        send(3'd0, 32'h00000001, 5'd31, 4'd11, 32'h80000000);
        send(3'd1, 32'h80000000, 5'd31, 4'd12, 32'h00000001);
        send(3'd0, 32'h80000000, 5'd1,  4'd13, 32'h00000000);
        send(3'd2, 32'h80000000, 5'd31, 4'd14, 32'hFFFFFFFF);
        send(3'd4, 32'h0000000F, 5'd4,  4'd15, ROT ? 32'hF0000000 : 32'h0000000F);
        drain();

        // Back-pressure: three slots fill, fourth waits
        out_ready = 1'b0;
        send(3'd0, 32'h00000001, 5'd1, 4'd1, 32'h00000002);
        send(3'd1, 32'h00000080, 5'd4, 4'd2, 32'h00000008);
        send(3'd2, 32'h80000000, 5'd4, 4'd3, 32'hF8000000);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_out_valid", 64'(out_valid), 64'd1);
        chk("hold_dout", 64'(dout), 64'h2);
        chk("hold_tag", 64'(out_tag), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_dout_later", 64'(dout), 64'h2);
        chk("hold_in_ready_later", 64'(in_ready), 64'd0);
        fork
            send(3'd6, 32'h00001234, 5'd3, 4'd4, 32'h00001234);
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
                #1;
                chk("full_in_ready_follows", 64'(in_ready), 64'd1);
            end
        join
        drain();

        // Random stream with random back-pressure
        fork
            begin
                for (int unsigned k = 0; k < 300; k++) begin
                    ro = 3'($urandom_range(0, 7));
                    rd = $urandom;
                    rs = 5'($urandom_range(0, 31));
                    send(ro, rd, rs, 4'(k), model(ro, rd, rs));
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with three operations in flight
        out_ready = 1'b0;
        send(3'd0, 32'h0000000F, 5'd4, 4'd1, 32'h000000F0);
        send(3'd1, 32'h0000F000, 5'd4, 4'd2, 32'h00000F00);
        send(3'd5, 32'h55555555, 5'd0, 4'd3, 32'h55555555);
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("midreset_in_ready_after", 64'(in_ready), 64'd1);
        for (int unsigned k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("midreset_no_ghost", 64'(out_valid), 64'd0);
        end
        send(3'd1, 32'hF0000000, 5'd28, 4'd9, 32'h0000000F);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
